// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: width helper,
// default pointer/count widths and the read-mode selector constants.
package fifo_pkg;

    // Ceiling log2, usable in constant expressions (clog2_f(1) == 0).
    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Widths for the default 16-entry configuration.
    localparam int DEF_DEPTH = 16;
    localparam int DEF_PTR_W = clog2_f(DEF_DEPTH);
    localparam int DEF_CNT_W = DEF_PTR_W + 1;

    // Read-mode selector values for the FWFT parameter.
    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer side of the FIFO: flush, write and read handshakes,
// read data and all status flags. The FIFO itself uses the slave view.
interface fifo_sync_param_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = clog2_f(DEPTH) + 1;

    logic              clr;
    logic              w_en;
    logic [DATA_W-1:0] data_in;
    logic              r_en;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport slave (
        input  clr, w_en, data_in, r_en,
        output data_out, valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport master (
        output clr, w_en, data_in, r_en,
        input  data_out, valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_mem_2p.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = clog2_f(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Store the incoming word at the write address.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty, sticky error flags, synchronous flush and an
// optional first-word-fall-through read mode.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = FWFT_OFF
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_sync_param_if.slave   bus
);
    localparam int PTR_W = clog2_f(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              full_s, empty_s;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] mem_rdata;

    // Flags come straight from the registered count.
    assign full_s  = (count_q == CNT_W'(DEPTH));
    assign empty_s = (count_q == '0);

    // A flush swallows both requests, so nothing is accepted in that cycle.
    assign wr_acc = bus.w_en && !full_s  && !bus.clr;
    assign rd_acc = bus.r_en && !empty_s && !bus.clr;

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            overflow_d  = overflow_q  | (bus.w_en && full_s);
            underflow_d = underflow_q | (bus.r_en && empty_s);
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.count        = count_q;
    assign bus.full         = full_s;
    assign bus.empty        = empty_s;
    assign bus.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    generate
        if (FWFT == FWFT_OFF) begin : g_reg_read
            logic [DATA_W-1:0] data_out_q;
            logic              valid_q;

            // Capture the head word on each accepted read; valid is a one-cycle pulse.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_out_q <= '0;
                    valid_q    <= 1'b0;
                end else begin
                    valid_q <= rd_acc;
                    if (rd_acc) begin
                        data_out_q <= mem_rdata;
                    end
                end
            end

            assign bus.data_out = data_out_q;
            assign bus.valid    = valid_q;
        end else begin : g_fwft
            // Head word is shown directly; the output is zero while empty.
            assign bus.data_out = empty_s ? '0 : mem_rdata;
            assign bus.valid    = !empty_s;
        end
    endgenerate
endmodule

// File: tb/tb_fifo_sync_param.sv
// Three FIFO configurations driven by one shared stimulus stream and checked
// every cycle against a queue-based reference model.
module tb_fifo_sync_param;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] data_in = 8'h00;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_sync_param_if #(.DATA_W(8), .DEPTH(4))  if0 ();
    fifo_sync_param_if #(.DATA_W(8), .DEPTH(4))  if1 ();
    fifo_sync_param_if #(.DATA_W(8), .DEPTH(16)) if2 ();

    assign if0.clr = clr;  assign if0.w_en = w_en;  assign if0.r_en = r_en;  assign if0.data_in = data_in;
    assign if1.clr = clr;  assign if1.w_en = w_en;  assign if1.r_en = r_en;  assign if1.data_in = data_in;
    assign if2.clr = clr;  assign if2.w_en = w_en;  assign if2.r_en = r_en;  assign if2.data_in = data_in;

    fifo_sync_param #(.DATA_W(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    fifo_sync_param #(.DATA_W(8), .DEPTH(4), .AF_LEVEL(2), .AE_LEVEL(1), .FWFT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));
    fifo_sync_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave));

    // Observed outputs gathered per instance.
    logic [4:0] cnt_o [3];
    logic [7:0] dout_o [3];
    logic       vld_o [3], full_o [3], empty_o [3], af_o [3], ae_o [3], ovf_o [3], unf_o [3];

    assign cnt_o[0] = {2'b00, if0.count};
    assign cnt_o[1] = {2'b00, if1.count};
    assign cnt_o[2] = if2.count;
    assign dout_o[0] = if0.data_out;  assign dout_o[1] = if1.data_out;  assign dout_o[2] = if2.data_out;
    assign vld_o[0]  = if0.valid;     assign vld_o[1]  = if1.valid;     assign vld_o[2]  = if2.valid;
    assign full_o[0] = if0.full;      assign full_o[1] = if1.full;      assign full_o[2] = if2.full;
    assign empty_o[0] = if0.empty;    assign empty_o[1] = if1.empty;    assign empty_o[2] = if2.empty;
    assign af_o[0] = if0.almost_full;  assign af_o[1] = if1.almost_full;  assign af_o[2] = if2.almost_full;
    assign ae_o[0] = if0.almost_empty; assign ae_o[1] = if1.almost_empty; assign ae_o[2] = if2.almost_empty;
    assign ovf_o[0] = if0.overflow;   assign ovf_o[1] = if1.overflow;   assign ovf_o[2] = if2.overflow;
    assign unf_o[0] = if0.underflow;  assign unf_o[1] = if1.underflow;  assign unf_o[2] = if2.underflow;

    // Reference model: one queue per instance plus the registered-mode outputs.
    logic [7:0] mq [3][$];
    int         depth_m [3];
    int         af_m [3];
    int         ae_m [3];
    bit         fwft_m [3];
    bit         ovf_m [3], unf_m [3], vld_m [3];
    logic [7:0] dout_m [3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            ovf_m[k]  = 1'b0;
            unf_m[k]  = 1'b0;
            vld_m[k]  = 1'b0;
            dout_m[k] = 8'h00;
        end
    endfunction

    // Apply one clock edge worth of requests to every model.
    function automatic void model_edge(input bit w, input bit r, input bit c, input logic [7:0] d);
        for (int k = 0; k < 3; k++) begin
            int sz;
            sz = mq[k].size();
            if (c) begin
                mq[k].delete();
                ovf_m[k] = 1'b0;
                unf_m[k] = 1'b0;
                vld_m[k] = 1'b0;
            end else begin
                if (w && sz == depth_m[k]) ovf_m[k] = 1'b1;
                if (r && sz == 0)          unf_m[k] = 1'b1;
                vld_m[k] = 1'b0;
                if (r && sz != 0) begin
                    dout_m[k] = mq[k].pop_front();
                    vld_m[k]  = 1'b1;
                end
                if (w && sz != depth_m[k]) mq[k].push_back(d);
            end
        end
    endfunction

    task automatic check_all(input string lbl);
        for (int k = 0; k < 3; k++) begin
            int sz;
            logic [7:0] head;
            sz = mq[k].size();
            head = (sz != 0) ? mq[k][0] : 8'h00;
            chk($sformatf("%s.u%0d.count", lbl, k), 32'(cnt_o[k]), 32'(sz));
            chk($sformatf("%s.u%0d.full", lbl, k),  32'(full_o[k]),  32'(sz == depth_m[k]));
            chk($sformatf("%s.u%0d.empty", lbl, k), 32'(empty_o[k]), 32'(sz == 0));
            chk($sformatf("%s.u%0d.afull", lbl, k), 32'(af_o[k]),    32'(sz >= af_m[k]));
            chk($sformatf("%s.u%0d.aempty", lbl, k), 32'(ae_o[k]),   32'(sz <= ae_m[k]));
            chk($sformatf("%s.u%0d.ovf", lbl, k),   32'(ovf_o[k]),   32'(ovf_m[k]));
            chk($sformatf("%s.u%0d.unf", lbl, k),   32'(unf_o[k]),   32'(unf_m[k]));
            if (fwft_m[k]) begin
                chk($sformatf("%s.u%0d.valid", lbl, k), 32'(vld_o[k]),  32'(sz != 0));
                chk($sformatf("%s.u%0d.dout", lbl, k),  32'(dout_o[k]), 32'(head));
            end else begin
                chk($sformatf("%s.u%0d.valid", lbl, k), 32'(vld_o[k]),  32'(vld_m[k]));
                chk($sformatf("%s.u%0d.dout", lbl, k),  32'(dout_o[k]), 32'(dout_m[k]));
            end
        end
    endtask

    // One transaction: drive requests, take the edge, update model, compare.
    task automatic step(input bit w, input bit r, input bit c, input logic [7:0] d);
        w_en = w; r_en = r; clr = c; data_in = d;
        @(posedge clk);
        model_edge(w, r, c, d);
        #1;
        $display("txn t=%0t w=%0b r=%0b clr=%0b d=%02h cnt=%0d/%0d/%0d",
                 $time, w, r, c, d, cnt_o[0], cnt_o[1], cnt_o[2]);
        check_all("step");
    endtask

    // Reset asserted between edges; its effect must be visible before any clock.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        $display("txn t=%0t async reset", $time);
        chk("arst.u2.count", 32'(cnt_o[2]), 32'd0);
        chk("arst.u2.empty", 32'(empty_o[2]), 32'd1);
        check_all("arst");
        w_en = 1'b0; r_en = 1'b0; clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        depth_m = '{4, 4, 16};
        af_m    = '{3, 2, 14};
        ae_m    = '{1, 1, 2};
        fwft_m  = '{1'b0, 1'b1, 1'b0};
        model_reset();

        // Reset state
        #12;
        check_all("reset");
        chk("reset.u2.aempty", 32'(ae_o[2]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Ordered write then read-back
        step(1, 0, 0, 8'h01); step(1, 0, 0, 8'h02); step(1, 0, 0, 8'h04);
        chk("p1.u0.count3", 32'(cnt_o[0]), 32'd3);
        step(0, 1, 0, 8'h00); chk("p1.u0.d0", 32'(dout_o[0]), 32'h01);
        step(0, 1, 0, 8'h00); chk("p1.u0.d1", 32'(dout_o[0]), 32'h02);
        step(0, 1, 0, 8'h00); chk("p1.u0.d2", 32'(dout_o[0]), 32'h04);
        chk("p1.u0.empty", 32'(empty_o[0]), 32'd1);

        // Fill, overflow, drain
        for (int i = 0; i < 4; i++) step(1, 0, 0, 8'(8'h10 + i));
        step(1, 0, 0, 8'hFF);
        chk("p2.u0.full", 32'(full_o[0]), 32'd1);
        chk("p2.u0.count", 32'(cnt_o[0]), 32'd4);
        chk("p2.u0.ovf", 32'(ovf_o[0]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 8'h00);
            chk("p2.u0.dout", 32'(dout_o[0]), 32'(8'h10 + i));
        end

        // Underflow then flush
        step(0, 1, 0, 8'h00);
        chk("p3.u0.unf", 32'(unf_o[0]), 32'd1);
        chk("p3.u0.count", 32'(cnt_o[0]), 32'd0);
        step(0, 0, 1, 8'h00);
        chk("p3.u0.unf_clr", 32'(unf_o[0]), 32'd0);
        chk("p3.u0.ovf_clr", 32'(ovf_o[0]), 32'd0);

        // Simultaneous read/write at full-1 with pointer wrap
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'(8'h20 + i));
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 0, 8'(8'h23 + i));
            chk("p4.u0.count", 32'(cnt_o[0]), 32'd3);
            chk("p4.u0.dout", 32'(dout_o[0]), 32'(8'h20 + i));
        end
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00);

        // First-word-fall-through on u1
        step(0, 0, 1, 8'h00);
        step(1, 0, 0, 8'hA5);
        chk("p5.u1.valid", 32'(vld_o[1]), 32'd1);
        chk("p5.u1.dout", 32'(dout_o[1]), 32'hA5);
        step(0, 1, 0, 8'h00);
        chk("p5.u1.empty", 32'(empty_o[1]), 32'd1);
        chk("p5.u1.valid0", 32'(vld_o[1]), 32'd0);

        // Almost-full / almost-empty thresholds on u2, then mid-stream reset
        step(0, 0, 1, 8'h00);
        for (int i = 0; i < 14; i++) begin
            step(1, 0, 0, 8'(8'h40 + i));
            chk("p6.u2.afull", 32'(af_o[2]), 32'((i + 1) >= 14));
        end
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 0, 8'h00);
            chk("p6.u2.aempty", 32'(ae_o[2]), 32'((13 - i) <= 2));
        end
        step(1, 0, 0, 8'h77);
        async_reset();
        step(1, 0, 0, 8'h5A);
        step(0, 1, 0, 8'h00);
        chk("p6.u2.first_after_rst", 32'(dout_o[2]), 32'h5A);

        // Randomized traffic with alternating fill/drain bias
        for (int i = 0; i < 1500; i++) begin
            int wp;
            bit w, r, c;
            wp = ((i / 150) % 2 == 0) ? 75 : 25;
            w = ($urandom_range(99) < wp);
            r = ($urandom_range(99) < (100 - wp));
            c = ($urandom_range(79) == 0);
            step(w, r, c, 8'($urandom));
            if ($urandom_range(399) == 0) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
